// File: rtl/nios2_debug_slave_vjtag_driver.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave.
// Takes one (IR, DR) scan command and plays the UIR/CDR/SDR/UDR/RTI sequence
// on the vji_* signals, capturing tdo into a DR_WIDTH-bit response.
module nios2_debug_slave_vjtag_driver #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int HC_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RESP = 3'd6
    } state_e;

    function automatic logic is_scan(input state_e s);
        return (s == S_UIR) || (s == S_CDR) || (s == S_SDR) || (s == S_UDR) || (s == S_RTI);
    endfunction

    // FSM and sequencing state
    state_e              state_q, state_d;
    logic [HC_W-1:0]     hc_q, hc_d;       // clk count within a tck half-period
    logic                ph_q, ph_d;       // 0: tck-low half, 1: tck-high half
    logic [BIT_W-1:0]    bit_q, bit_d;     // SDR bit index
    logic [RTI_W-1:0]    rti_cnt_q, rti_cnt_d;
    logic [DR_WIDTH-1:0] dr_q, dr_d;       // latched command data
    logic [DR_WIDTH-1:0] cap_q, cap_d;     // tdo capture shift register

    // Registered outputs
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
    logic                busy_q, busy_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;

    logic accept, scanning, hc_last, tck_rise, period_end;

    assign accept     = cmd_valid && cmd_ready_q;
    assign scanning   = is_scan(state_q);
    assign hc_last    = (hc_q == HC_W'(TCK_DIV - 1));
    assign tck_rise   = scanning && !ph_q && hc_last;   // this edge raises tck
    assign period_end = scanning && ph_q && hc_last;    // this edge starts a new period

    // State register: everything returns to IDLE immediately on reset
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            hc_q      <= '0;
            ph_q      <= 1'b0;
            bit_q     <= '0;
            rti_cnt_q <= '0;
            dr_q      <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            rti_cnt_q <= rti_cnt_d;
            dr_q      <= dr_d;
            cap_q     <= cap_d;
        end
    end

    // Next-state logic: tck phase tracking and state advance on period boundaries
    // NOTE: every variable gets a hold default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        rti_cnt_d = rti_cnt_q;
        dr_d      = dr_q;
        cap_d     = cap_q;

        if (scanning) begin
            hc_d = hc_last ? '0 : hc_q + HC_W'(1);
            if (hc_last) ph_d = ~ph_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_UIR;
                    dr_d    = cmd_dr;
                    hc_d    = '0;
                    ph_d    = 1'b0;
                end
            end
            S_UIR: if (period_end) state_d = S_CDR;
            S_CDR: begin
                if (period_end) begin
                    state_d = S_SDR;
                    bit_d   = '0;
                end
            end
            S_SDR: begin
                if (tck_rise) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
                if (period_end) begin
                    if (bit_q == BIT_W'(DR_WIDTH - 1)) begin
                        state_d = S_UDR;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_UDR: begin
                if (period_end) begin
                    state_d   = S_RTI;
                    rti_cnt_d = '0;
                end
            end
            S_RTI: begin
                if (period_end) begin
                    if (rti_cnt_q == RTI_W'(RTI_CYCLES - 1)) begin
                        state_d   = S_RESP;
                        rti_cnt_d = '0;
                    end else begin
                        rti_cnt_d = rti_cnt_q + RTI_W'(1);
                    end
                end
            end
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: outputs are decoded from the next state so they register glitch-free
    always_comb begin
        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        tck_d        = is_scan(state_d) && ph_d;
        tdi_d        = (state_d == S_SDR) ? dr_d[bit_d] : 1'b0;
        uir_d        = (state_d == S_UIR);
        cdr_d        = (state_d == S_CDR);
        sdr_d        = (state_d == S_SDR);
        udr_d        = (state_d == S_UDR);
        rti_d        = (state_d == S_RTI);
        rsp_valid_d  = (state_d == S_RESP);
        ir_in_d      = accept ? cmd_ir : ir_in_q;
        rsp_ir_out_d = ((state_q == S_UIR) && tck_rise) ? vji_ir_out : rsp_ir_out_q;
        rsp_dr_d     = ((state_d == S_RESP) && (state_q != S_RESP)) ? cap_q : rsp_dr_q;
    end

    // Output registers: all outputs clear asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dr_q     <= '0;
            rsp_ir_out_q <= '0;
            busy_q       <= 1'b0;
            tck_q        <= 1'b0;
            tdi_q        <= 1'b0;
            ir_in_q      <= '0;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
            rti_q        <= 1'b0;
        end else begin
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dr_q     <= rsp_dr_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            busy_q       <= busy_d;
            tck_q        <= tck_d;
            tdi_q        <= tdi_d;
            ir_in_q      <= ir_in_d;
            uir_q        <= uir_d;
            cdr_q        <= cdr_d;
            sdr_q        <= sdr_d;
            udr_q        <= udr_d;
            rti_q        <= rti_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign busy       = busy_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;
    assign vji_rti    = rti_q;

endmodule

// File: tb/tb_nios2_debug_slave_vjtag_driver.sv
// Bench for nios2_debug_slave_vjtag_driver: a default build with a 38-bit
// debug-slave model, plus a TCK_DIV=1 / RTI_CYCLES=3 build for timing.
module tb_nios2_debug_slave_vjtag_driver;

    localparam int DRW = 38;
    localparam int IRW = 2;

    typedef struct packed {
        logic [DRW-1:0] dr;
        logic [IRW-1:0] ir;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    rsp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- default build ----------------
    logic           cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
    logic [IRW-1:0] cmd_ir = '0, rsp_ir_out, vji_ir_in, vji_ir_out = '0;
    logic [DRW-1:0] cmd_dr = '0, rsp_dr;
    logic           vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_debug_slave_vjtag_driver dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Debug-slave model: load at CDR, shift on SDR, record at UDR
    logic [DRW-1:0] sr0 = '0, load0 = '0, sr0_udr = '0;
    assign vji_tdo = sr0[0];
    always @(posedge vji_tck) begin
        if (vji_cdr)      sr0 <= load0;
        else if (vji_sdr) sr0 <= {vji_tdi, sr0[DRW-1:1]};
        else if (vji_udr) sr0_udr <= sr0;
    end

    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_overlap = 0;
    time t_last0 = 0, t_per0 = 0;
    always @(posedge vji_tck) begin
        if (vji_uir) n_uir++;
        if (vji_cdr) n_cdr++;
        if (vji_sdr) n_sdr++;
        if (vji_udr) n_udr++;
        if (vji_rti) n_rti++;
        t_per0 = $time - t_last0;
        t_last0 = $time;
    end
    always @(negedge clk)
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_overlap++;

    // ---------------- TCK_DIV=1, RTI_CYCLES=3 build ----------------
    logic           c1_valid = 1'b0, c1_ready, r1_valid, r1_ready = 1'b0, busy1;
    logic [IRW-1:0] c1_ir = '0, r1_ir_out, ir_in1, ir_out1 = '0;
    logic [DRW-1:0] c1_dr = '0, r1_dr;
    logic           tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;

    nios2_debug_slave_vjtag_driver #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1), .RTI_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_dr(c1_dr),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_dr(r1_dr), .rsp_ir_out(r1_ir_out),
        .busy(busy1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
        .vji_ir_in(ir_in1), .vji_ir_out(ir_out1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    logic [DRW-1:0] sr1 = '0, load1 = '0, sr1_udr = '0;
    int n1_rti = 0, n1_uir = 0;
    time t_last1 = 0, t_per1 = 0;
    assign tdo1 = sr1[0];
    always @(posedge tck1) begin
        if (cdr1)      sr1 <= load1;
        else if (sdr1) sr1 <= {tdi1, sr1[DRW-1:1]};
        else if (udr1) sr1_udr <= sr1;
    end
    always @(posedge tck1) begin
        if (rti1) n1_rti++;
        if (uir1) n1_uir++;
        t_per1 = $time - t_last1;
        t_last1 = $time;
    end

    function automatic logic [63:0] outs0();
        return 64'({cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_uir, vji_cdr,
                    vji_sdr, vji_udr, vji_rti, vji_ir_in, rsp_ir_out});
    endfunction

    // One complete scan on the default build, optionally with response back-pressure
    task automatic scan0(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                         input logic [DRW-1:0] load, input logic [IRW-1:0] iro, input bit hold);
        int b_uir, b_cdr, b_sdr, b_udr, b_rti, b_ovl, acc, bad;
        rsp_t e;
        b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr; b_rti = n_rti; b_ovl = n_overlap;
        load0 = load;
        vji_ir_out = iro;
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
        e.dr = load; e.ir = iro;
        sb.push_back(e);
        @(negedge clk);
        acc = cyc;
        cmd_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("ready_after_accept", 64'(cmd_ready), 64'd0);
        check("ir_in_held", 64'(vji_ir_in), 64'(ir));
        for (int i = 0; i < 1000 && !rsp_valid; i++) @(negedge clk);
        check("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
        check("latency", 64'(cyc - acc), 64'd168);
        check("tck_period_clk", 64'(t_per0), 64'd40);
        if (sb.size() > 0) e = sb.pop_front();
        check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        check("rsp_ir_out", 64'(rsp_ir_out), 64'(e.ir));
        check("slave_sr_at_udr", 64'(sr0_udr), 64'(dr));
        if (hold) begin
            bad = 0;
            cmd_valid = 1'b1;
            cmd_dr = ~dr;
            repeat (20) begin
                @(negedge clk);
                if (!(rsp_valid === 1'b1 && rsp_dr === e.dr && cmd_ready === 1'b0 && vji_tck === 1'b0)) bad++;
            end
            cmd_valid = 1'b0;
            check("backpressure_hold_bad_cycles", 64'(bad), 64'd0);
        end
        check("uir_periods", 64'(n_uir - b_uir), 64'd1);
        check("cdr_periods", 64'(n_cdr - b_cdr), 64'd1);
        check("sdr_periods", 64'(n_sdr - b_sdr), 64'd38);
        check("udr_periods", 64'(n_udr - b_udr), 64'd1);
        check("rti_periods", 64'(n_rti - b_rti), 64'd1);
        check("flag_overlap", 64'(n_overlap - b_ovl), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
        check("busy_after_hs", 64'(busy), 64'd0);
        check("ready_after_hs", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int b_sdr, b_udr, acc;
        rsp_t e;

        // Reset state and release
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs", outs0(), 64'd0);
        check("reset_rsp_dr", 64'(rsp_dr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_first_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("ready_one_edge_after_release", 64'(cmd_ready), 64'd1);

        // Main scan with back-pressure on the response
        scan0(2'b01, 38'h2A_5A5A_5A5A, 38'h15_DEAD_BEEF, 2'b10, 1'b1);

        // Reset mid-SDR after 10 bits
        b_sdr = n_sdr; b_udr = n_udr;
        load0 = 38'h0F_1234_5678;
        cmd_ir = 2'b10; cmd_dr = 38'h3F_0000_FFFF; cmd_valid = 1'b1;
        e.dr = load0; e.ir = 2'b01;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000 && (n_sdr - b_sdr) < 10; i++) @(negedge clk);
        check("abort_reached_10_bits", 64'(n_sdr - b_sdr), 64'd10);
        #2 reset_n = 1'b0;
        #1;
        check("abort_outputs_zero", outs0(), 64'd0);
        check("abort_rsp_dr_zero", 64'(rsp_dr), 64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after_release", 64'(cmd_ready), 64'd1);
        repeat (10) @(negedge clk);
        check("abort_no_udr", 64'(n_udr - b_udr), 64'd0);
        check("abort_slave_untouched", 64'(sr0_udr), 64'(38'h2A_5A5A_5A5A));
        scan0(2'b11, 38'h3F_0000_FFFF, 38'h0F_1234_5678, 2'b01, 1'b0);

        // Fast build: TCK_DIV=1, RTI_CYCLES=3
        load1 = 38'h2B_CAFE_F00D;
        ir_out1 = 2'b11;
        check("fast_ready", 64'(c1_ready), 64'd1);
        c1_ir = 2'b10; c1_dr = 38'h11_2233_4455; c1_valid = 1'b1;
        e.dr = load1; e.ir = ir_out1;
        sb.push_back(e);
        @(negedge clk);
        acc = cyc;
        c1_valid = 1'b0;
        check("fast_busy", 64'(busy1), 64'd1);
        check("fast_ir_in", 64'(ir_in1), 64'(2'b10));
        for (int i = 0; i < 1000 && !r1_valid; i++) @(negedge clk);
        check("fast_rsp_valid_arrives", 64'(r1_valid), 64'd1);
        check("fast_latency", 64'(cyc - acc), 64'd88);
        check("fast_tck_period", 64'(t_per1), 64'd20);
        if (sb.size() > 0) e = sb.pop_front();
        check("fast_rsp_dr", 64'(r1_dr), 64'(e.dr));
        check("fast_rsp_ir_out", 64'(r1_ir_out), 64'(e.ir));
        check("fast_slave_sr_at_udr", 64'(sr1_udr), 64'(38'h11_2233_4455));
        check("fast_rti_periods", 64'(n1_rti), 64'd3);
        check("fast_uir_periods", 64'(n1_uir), 64'd1);
        r1_ready = 1'b1;
        @(negedge clk);
        r1_ready = 1'b0;
        check("fast_rsp_valid_after_hs", 64'(r1_valid), 64'd0);
        @(negedge clk);
        check("fast_ready_after_hs", 64'(c1_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
